// File: rtl/multdiv_unit_pkg.sv
// Shared constants, ALU opcodes and FSM encodings for the iterative
// multiply/divide unit.
package multdiv_unit_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_md_step.sv
// One iteration of the shared datapath: radix-2 Booth step (mode_div=0) or
// restoring-division step (mode_div=1) on the {hi, lo} accumulator pair.
module multdiv_unit_md_step
  import multdiv_unit_pkg::*;
(
  input  logic             mode_div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic             qm1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             qm1_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = hi;
    r_sh    = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff    = r_sh - m;
    hi_nxt  = hi;
    lo_nxt  = lo;
    qm1_nxt = qm1;
    if (mode_div) begin
      // Partial remainder stays below 2*divisor, so bit WIDTH of diff is a true sign.
      qm1_nxt = 1'b0;
      if (!diff[WIDTH]) begin
        hi_nxt = diff;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = r_sh;
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      case ({lo[0], qm1})
        2'b01:   sum = hi + m;
        2'b10:   sum = hi - m;
        default: sum = hi;
      endcase
      hi_nxt  = {sum[WIDTH], sum[WIDTH:1]};
      lo_nxt  = {sum[0], lo[WIDTH-1:1]};
      qm1_nxt = lo[0];
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage:
// FSM, iteration counter and operand/result registers around md_step.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic             rise,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [4:0]       rd_out,
  output state_t           dbg_state
);

  // Handshake: ctrl_mult/ctrl_div are single-cycle issue pulses, taken only at
  // an edge in IDLE or DONE (mult wins a tie) and ignored while busy. result,
  // exception and rd_out are valid in the one cycle result_rdy is high and are
  // held until the next completion; there is no back-pressure on the result.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ITER);

  state_t state, state_nxt;

  logic [WIDTH:0]   hi_q, hi_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt;
  logic             qm1_q, qm1_nxt;
  logic [WIDTH:0]   m_q;
  logic             neg_q;
  logic             fast_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_mult, load_div, step_en, finish;
  logic             div_fast;
  logic [WIDTH-1:0] res_nxt;
  logic             exc_nxt;

  assign div_fast = (operand_b == '0) ||
                    (operand_a == {1'b1, {(WIDTH-1){1'b0}}} && operand_b == '1);

  multdiv_unit_md_step u_step (
    .mode_div (state == ST_DIV),
    .hi       (hi_q),
    .lo       (lo_q),
    .qm1      (qm1_q),
    .m        (m_q),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt),
    .qm1_nxt  (qm1_nxt)
  );

  always_ff @(posedge rise or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_mult = 1'b0;
    load_div  = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (ctrl_mult) begin
          load_mult = 1'b1;
          state_nxt = ST_MULT;
        end else if (ctrl_div) begin
          load_div  = 1'b1;
          state_nxt = ST_DIV;
        end
      end
      ST_MULT: begin
        step_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DIV: begin
        if (fast_q) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            finish    = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Results are formed from the post-step values so they land on the final iteration edge.
  always_comb begin
    res_nxt = lo_nxt;
    exc_nxt = 1'b0;
    if (state == ST_MULT) begin
      res_nxt = lo_nxt;
      exc_nxt = (hi_nxt[WIDTH-1:0] != {WIDTH{lo_nxt[WIDTH-1]}});
    end else if (fast_q) begin
      res_nxt = '0;
      exc_nxt = 1'b1;
    end else begin
      res_nxt = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
    end
  end

  always_ff @(posedge rise or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      neg_q     <= 1'b0;
      fast_q    <= 1'b0;
      rd_q      <= '0;
      cnt_q     <= '0;
      result    <= '0;
      exception <= 1'b0;
      rd_out    <= '0;
    end else begin
      if (load_mult) begin
        hi_q   <= '0;
        lo_q   <= operand_b;
        qm1_q  <= 1'b0;
        m_q    <= {operand_a[WIDTH-1], operand_a};
        neg_q  <= 1'b0;
        fast_q <= 1'b0;
        rd_q   <= rd_in;
        cnt_q  <= '0;
      end else if (load_div) begin
        hi_q   <= '0;
        lo_q   <= magnitude(operand_a);
        qm1_q  <= 1'b0;
        m_q    <= {1'b0, magnitude(operand_b)};
        neg_q  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        fast_q <= div_fast;
        rd_q   <= rd_in;
        cnt_q  <= '0;
      end else if (step_en) begin
        hi_q  <= hi_nxt;
        lo_q  <= lo_nxt;
        qm1_q <= qm1_nxt;
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        result    <= res_nxt;
        exception <= exc_nxt;
        rd_out    <= rd_q;
      end
    end
  end

  assign busy       = (state == ST_MULT) || (state == ST_DIV);
  assign result_rdy = (state == ST_DONE);
  assign dbg_state  = state;

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide responder for the execute stage.
- Accepts a one-cycle issue pulse qualified from the D/X decode (mult/div decode AND not-noop) with both operands and the destination register.
- Computes over 32 iteration cycles, then returns the result, destination register and exception flag with a one-cycle ready pulse.
- busy is fed back to the hazard logic so the pipeline holds stall_dx while an operation is in flight.

Parameters:
- WIDTH, 32, operand and result width.
- ITER, 32, iteration cycles per operation (equals WIDTH).

Ports:
- rise  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ctrl_mult  in  1  issue multiply, single-cycle pulse
- ctrl_div  in  1  issue divide, single-cycle pulse
- operand_a  in  32  multiplicand / dividend (read1 value)
- operand_b  in  32  multiplier / divisor (read2 value)
- rd_in  in  5  destination register of the issuing instruction
- busy  out  1  operation in flight
- result_rdy  out  1  one-cycle pulse: result, rd_out and exception valid
- result  out  32  low 32 bits of product, or quotient
- exception  out  1  overflow or divide-by-zero
- rd_out  out  5  destination register captured at issue

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, result_rdy and exception = 0; result = 0; rd_out = 0; counter = 0.
- States:
  - IDLE: wait for issue.
  - MULT, DIV: iterate.
  - DONE: one cycle, result_rdy=1.
- Issue
  - Sampled at a rising edge in IDLE or DONE.
  - ctrl_mult has priority if ctrl_mult and ctrl_div arrive together.
  - At the issue edge: capture operands and rd_in, counter = 0, busy=1 from the next cycle.
  - Issue pulses in MULT or DIV are ignored: no capture, no state change.
- MULT
  - Radix-2 Booth on the 32-bit operands, one step per cycle, 64-bit accumulator.
  - After ITER steps: result = product[31:0].
  - exception = 1 iff product[63:32] is not the sign extension of product[31].
- DIV
  - Restoring division on operand magnitudes, one quotient bit per cycle.
  - Sign = a[31] XOR b[31]; quotient truncates toward zero; remainder discarded.
- Divide-by-zero (operand_b = 0 at issue): skip iteration, go to DONE on the next edge; result = 0, exception = 1.
- INT_MIN / -1: result = 0, exception = 1 (detected at issue, same fast path as divide-by-zero).
- Latency
  - Normal operation: result_rdy high during the 33rd cycle after the issue edge (32 iteration edges, then DONE).
  - Fast path: result_rdy high during the 2nd cycle after the issue edge.
- DONE
  - busy = 0 in DONE.
  - result_rdy = 1 for exactly one cycle.
  - Back-to-back issue is accepted in DONE.
  - Without an issue, DONE → IDLE.
- Output hold: result, exception and rd_out hold their values until the next DONE; they are not cleared in IDLE.
- Reset mid-operation: aborts immediately; no result_rdy pulse; all outputs return to reset values.
- Counter: 6-bit, saturates at ITER and never wraps.

Decomposition:
- Shared package (project-wide):
  - ALU opcodes MULT=5'b00110 and DIV=5'b00111.
  - WIDTH and ITER constants.
  - State encodings IDLE/MULT/DIV/DONE.
- Sub-module md_step: combinational one-iteration datapath.
  - Booth add/subtract-and-shift, or restoring subtract-and-shift, selected by a mode bit.
  - Top level holds the FSM, counter and registers.

Test Plan:
- mult 7×6, rd_in=5 → result_rdy pulse 33 cycles after issue; result=42, exception=0, rd_out=5; busy high for cycles 1–32.
- mult -3×5, then 0x00010000×0x00010000 → first: result=0xFFFFFFF1, exception=0. Second: result=0x00000000, exception=1.
- div 100/7, -100/7, 100/-7 → results 14, 0xFFFFFFF2, 0xFFFFFFF2; exception=0 each.
- div 5/0 and 0x80000000/0xFFFFFFFF → result_rdy 2 cycles after issue; result=0, exception=1.
- Issue mult 2×3, pulse ctrl_div with 9/3 at cycle 10 → second issue ignored; result=6. Then issue 9/3 in the DONE cycle → result 3 after 33 cycles.
- Drop reset at cycle 15 of a mult → busy, result_rdy and result all 0 asynchronously; no result_rdy pulse after reset releases.
